// File: rtl/elm_layer_ctrl.sv
// Layer sequencer for an extreme-learning-machine hidden layer.
// Streams NUM_INPUT samples to all neurons and collects one result per neuron.
// It then drains the results in neuron order over a valid/ready handshake.
`ifndef dataWidth
`define dataWidth 16
`endif
`ifndef ROM_bitwidth
`define ROM_bitwidth 16
`endif

module elm_layer_ctrl #(
  parameter int NUM_INPUT  = 128,
  parameter int NUM_NEURON = 64,
  parameter int DW         = `dataWidth,
  parameter int OW         = `ROM_bitwidth,
  parameter int TIMEOUT    = 16,
  localparam int IW        = (NUM_NEURON > 1) ? $clog2(NUM_NEURON) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [DW-1:0]          in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DW-1:0]          neu_in,
  output logic                   neu_in_valid,
  input  logic [NUM_NEURON-1:0]  neu_outvalid,
  input  logic [NUM_NEURON*OW-1:0] neu_out,
  output logic [OW-1:0]          res_data,
  output logic [IW-1:0]          res_idx,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   err_timeout
);

  localparam int CW = $clog2(NUM_INPUT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] IN_LAST  = CW'(NUM_INPUT - 1);
  localparam logic [CW-1:0] IN_MAX   = CW'(NUM_INPUT);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_NEURON - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FEED  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t                 state_r, state_nxt_s;
  logic [CW-1:0]          in_cnt_r;
  logic [TW-1:0]          wait_cnt_r;
  logic [IW-1:0]          idx_r;
  logic [NUM_NEURON-1:0]  mask_r;
  logic [OW-1:0]          rbuf_r [NUM_NEURON];
  logic                   err_r;
  logic [DW-1:0]          neu_in_r;
  logic                   neu_in_valid_r;

  logic start_acc_s, accept_s, mask_full_s, capture_en_s, timeout_hit_s, res_fire_s;

  assign start_acc_s   = (state_r == ST_IDLE) && start;
  assign accept_s      = in_valid && in_ready;
  assign mask_full_s   = &mask_r;
  assign capture_en_s  = (state_r == ST_FEED) || (state_r == ST_WAIT);
  // Full mask has priority: a pass that completes never reports a timeout.
  assign timeout_hit_s = (state_r == ST_WAIT) && !mask_full_s && (wait_cnt_r >= TO_LAST);
  assign res_fire_s    = res_valid && res_ready;

  assign neu_in       = neu_in_r;
  assign neu_in_valid = neu_in_valid_r;
  assign err_timeout  = err_r;
  assign res_idx      = idx_r;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= ST_IDLE;
    else      state_r <= state_nxt_s;
  end

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:  if (start_acc_s) state_nxt_s = ST_FEED; else state_nxt_s = ST_IDLE;
      ST_FEED:  if (accept_s && (in_cnt_r == IN_LAST)) state_nxt_s = ST_WAIT;
                else state_nxt_s = ST_FEED;
      ST_WAIT:  if (mask_full_s || timeout_hit_s) state_nxt_s = ST_DRAIN;
                else state_nxt_s = ST_WAIT;
      ST_DRAIN: if (res_fire_s && (idx_r == IDX_LAST)) state_nxt_s = ST_DONE;
                else state_nxt_s = ST_DRAIN;
      ST_DONE:  state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Output decode from the registered state and result buffers
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b1;
    res_valid = 1'b0;
    done      = 1'b0;
    case (state_r)
      ST_IDLE:  busy      = 1'b0;
      ST_FEED:  in_ready  = 1'b1;
      ST_WAIT:  busy      = 1'b1;
      ST_DRAIN: res_valid = 1'b1;
      ST_DONE:  done      = 1'b1;
      default:  busy      = 1'b0;
    endcase
    res_data = rbuf_r[idx_r];
  end

  // Input beat counter and one-cycle-latency broadcast to the neurons
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_cnt_r       <= '0;
      neu_in_r       <= '0;
      neu_in_valid_r <= 1'b0;
    end else begin
      neu_in_valid_r <= accept_s;
      if (accept_s) neu_in_r <= in_data;
      else          neu_in_r <= neu_in_r;
      if (start_acc_s)                           in_cnt_r <= '0;
      else if (accept_s && (in_cnt_r != IN_MAX)) in_cnt_r <= in_cnt_r + CW'(1);
      else                                       in_cnt_r <= in_cnt_r;
    end
  end

  // First-response capture per neuron; later pulses for a captured neuron are dropped
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask_r <= '0;
      for (int k = 0; k < NUM_NEURON; k++) rbuf_r[k] <= '0;
    end else if (start_acc_s) begin
      mask_r <= '0;
      for (int k = 0; k < NUM_NEURON; k++) rbuf_r[k] <= '0;
    end else if (capture_en_s) begin
      for (int k = 0; k < NUM_NEURON; k++) begin
        if (neu_outvalid[k] && !mask_r[k]) begin
          rbuf_r[k] <= neu_out[k*OW +: OW];
          mask_r[k] <= 1'b1;
        end else begin
          rbuf_r[k] <= rbuf_r[k];
          mask_r[k] <= mask_r[k];
        end
      end
    end else begin
      mask_r <= mask_r;
    end
  end

  // WAIT-phase cycle counter and sticky timeout flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_r <= '0;
      err_r      <= 1'b0;
    end else begin
      if (start_acc_s)                                         wait_cnt_r <= '0;
      else if ((state_r == ST_WAIT) && (wait_cnt_r != TO_MAX)) wait_cnt_r <= wait_cnt_r + TW'(1);
      else                                                     wait_cnt_r <= wait_cnt_r;
      if (start_acc_s)        err_r <= 1'b0;
      else if (timeout_hit_s) err_r <= 1'b1;
      else                    err_r <= err_r;
    end
  end

  // Drain index, advanced on each accepted result and held at the last neuron
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                     idx_r <= '0;
    else if (start_acc_s)                         idx_r <= '0;
    else if (res_fire_s && (idx_r != IDX_LAST))   idx_r <= idx_r + IW'(1);
    else                                          idx_r <= idx_r;
  end

endmodule

// File: tb/tb_elm_layer_ctrl.sv
// Self-checking bench for elm_layer_ctrl with NUM_INPUT=4, NUM_NEURON=3.
module tb_elm_layer_ctrl;
  localparam int NI = 4, NN = 3, DW = 8, OW = 8, TO = 16, IW = 2;

  logic clk, rst, start, in_valid, in_ready, neu_in_valid;
  logic res_valid, res_ready, busy, done, err_timeout;
  logic [DW-1:0] in_data, neu_in;
  logic [NN-1:0] neu_outvalid;
  logic [NN*OW-1:0] neu_out;
  logic [OW-1:0] res_data;
  logic [IW-1:0] res_idx;

  int n_checks = 0;
  int n_pass = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  elm_layer_ctrl #(.NUM_INPUT(NI), .NUM_NEURON(NN), .DW(DW), .OW(OW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .neu_in(neu_in), .neu_in_valid(neu_in_valid),
    .neu_outvalid(neu_outvalid), .neu_out(neu_out), .res_data(res_data),
    .res_idx(res_idx), .res_valid(res_valid), .res_ready(res_ready),
    .busy(busy), .done(done), .err_timeout(err_timeout)
  );

  // Reference model: a pass is tracked by counts (beats taken, wait cycles,
  // neurons answered, results drained) rather than by a state machine.
  bit m_active, m_in_done, m_wait_done, m_err, m_nv;
  int m_beats, m_wcyc, m_drain;
  logic [NN-1:0] m_got;
  logic [OW-1:0] m_val [NN];
  logic [DW-1:0] m_ni;

  typedef struct {
    logic st, iv; logic [7:0] id; logic [2:0] ov; logic [23:0] no; logic rr;
    logic e_busy, e_done, e_rdy, e_nv; logic [7:0] e_ni; logic e_rv;
    logic [1:0] e_idx; logic [7:0] e_rd;
  } vec_t;
  vec_t tbl [11];

  function automatic logic [23:0] pack_act();
    return {busy, done, err_timeout, in_ready, neu_in_valid, neu_in, res_valid, res_idx, res_data};
  endfunction

  function automatic logic [23:0] pack_exp();
    logic rdy, rv;
    rdy = m_active && !m_in_done && (m_beats < NI);
    rv  = m_active && !m_in_done && (m_beats == NI) && m_wait_done;
    return {m_active, m_in_done, m_err, rdy, m_nv, m_ni, rv, 2'(m_drain), m_val[m_drain]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic m_reset();
    m_active = 1'b0; m_in_done = 1'b0; m_wait_done = 1'b0; m_err = 1'b0; m_nv = 1'b0;
    m_beats = 0; m_wcyc = 0; m_drain = 0; m_got = '0; m_ni = '0;
    for (int k = 0; k < NN; k++) m_val[k] = '0;
  endtask

  task automatic m_capture(input logic [NN-1:0] ov, input logic [NN*OW-1:0] no);
    for (int k = 0; k < NN; k++)
      if (ov[k] && !m_got[k]) begin m_got[k] = 1'b1; m_val[k] = no[k*OW +: OW]; end
  endtask

  task automatic m_step(input logic st, input logic iv, input logic [DW-1:0] id,
                        input logic [NN-1:0] ov, input logic [NN*OW-1:0] no, input logic rr);
    m_nv = 1'b0;
    if (m_in_done) begin
      m_in_done = 1'b0; m_active = 1'b0;
    end else if (!m_active) begin
      if (st) begin
        m_active = 1'b1; m_beats = 0; m_wcyc = 0; m_wait_done = 1'b0; m_drain = 0;
        m_got = '0; m_err = 1'b0;
        for (int k = 0; k < NN; k++) m_val[k] = '0;
      end
    end else if (m_beats < NI) begin
      if (iv) begin m_beats++; m_ni = id; m_nv = 1'b1; end
      m_capture(ov, no);
    end else if (!m_wait_done) begin
      if (&m_got) m_wait_done = 1'b1;
      else begin
        m_capture(ov, no);
        m_wcyc++;
        if (m_wcyc == TO) begin m_err = 1'b1; m_wait_done = 1'b1; end
      end
    end else if (rr) begin
      if (m_drain == NN - 1) m_in_done = 1'b1;
      else m_drain++;
    end
  endtask

  // One clock: drive inputs, advance the model, compare every output after the edge.
  task automatic cyc(input logic st, input logic iv, input logic [DW-1:0] id,
                     input logic [NN-1:0] ov, input logic [NN*OW-1:0] no, input logic rr);
    start = st; in_valid = iv; in_data = id; neu_outvalid = ov; neu_out = no; res_ready = rr;
    m_step(st, iv, id, ov, no, rr);
    @(posedge clk); #1;
    check("model", {8'h00, pack_act()}, {8'h00, pack_exp()});
  endtask

  task automatic idle_cyc(input logic rr);
    cyc(1'b0, 1'b0, 8'h00, 3'b000, 24'h000000, rr);
  endtask

  task automatic start_feed4();
    cyc(1'b1, 1'b0, 8'h00, 3'b000, 24'h000000, 1'b0);
    for (int i = 1; i <= NI; i++) cyc(1'b0, 1'b1, 8'(i), 3'b000, 24'h000000, 1'b0);
  endtask

  task automatic finish_pass(input string name);
    int n;
    n = 0;
    while (m_active && n < 100) begin
      cyc(1'b0, 1'b1, 8'($urandom), 3'b111, 24'($urandom), 1'b1);
      n++;
    end
    check(name, {31'd0, busy}, 32'd0);
  endtask

  // Assert reset between edges and require the reset values before any clock edge.
  task automatic async_reset(input string name);
    #2 rst = 1'b0;
    #1;
    m_reset();
    check(name, {8'h00, pack_act()}, 32'd0);
    start = 1'b0; in_valid = 1'b0; neu_outvalid = '0; res_ready = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    idle_cyc(1'b1);
    idle_cyc(1'b0);
  endtask

  initial begin
    int pulses;
    logic gp [6];
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    neu_outvalid = '0; neu_out = '0; res_ready = 1'b0;
    m_reset();
    #1 check("reset_state", {8'h00, pack_act()}, 32'd0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b1;
    cyc(1'b0, 1'b1, 8'h55, 3'b111, 24'hABCDEF, 1'b1);
    idle_cyc(1'b0);

    // Nominal pass, expected values written out by hand.
    tbl[0]  = '{1'b1,1'b0,8'h00,3'b000,24'h000000,1'b0, 1'b1,1'b0,1'b1,1'b0,8'h00,1'b0,2'd0,8'h00};
    tbl[1]  = '{1'b0,1'b1,8'h01,3'b000,24'h000000,1'b0, 1'b1,1'b0,1'b1,1'b1,8'h01,1'b0,2'd0,8'h00};
    tbl[2]  = '{1'b0,1'b1,8'h02,3'b000,24'h000000,1'b0, 1'b1,1'b0,1'b1,1'b1,8'h02,1'b0,2'd0,8'h00};
    tbl[3]  = '{1'b0,1'b1,8'h03,3'b000,24'h000000,1'b0, 1'b1,1'b0,1'b1,1'b1,8'h03,1'b0,2'd0,8'h00};
    tbl[4]  = '{1'b0,1'b1,8'h04,3'b000,24'h000000,1'b0, 1'b1,1'b0,1'b0,1'b1,8'h04,1'b0,2'd0,8'h00};
    tbl[5]  = '{1'b0,1'b0,8'h00,3'b111,24'h302010,1'b0, 1'b1,1'b0,1'b0,1'b0,8'h04,1'b0,2'd0,8'h10};
    tbl[6]  = '{1'b0,1'b0,8'h00,3'b000,24'h000000,1'b1, 1'b1,1'b0,1'b0,1'b0,8'h04,1'b1,2'd0,8'h10};
    tbl[7]  = '{1'b0,1'b0,8'h00,3'b000,24'h000000,1'b1, 1'b1,1'b0,1'b0,1'b0,8'h04,1'b1,2'd1,8'h20};
    tbl[8]  = '{1'b0,1'b0,8'h00,3'b000,24'h000000,1'b1, 1'b1,1'b0,1'b0,1'b0,8'h04,1'b1,2'd2,8'h30};
    tbl[9]  = '{1'b0,1'b0,8'h00,3'b000,24'h000000,1'b1, 1'b1,1'b1,1'b0,1'b0,8'h04,1'b0,2'd2,8'h30};
    tbl[10] = '{1'b0,1'b0,8'h00,3'b000,24'h000000,1'b0, 1'b0,1'b0,1'b0,1'b0,8'h04,1'b0,2'd2,8'h30};
    for (int i = 0; i < 11; i++) begin
      cyc(tbl[i].st, tbl[i].iv, tbl[i].id, tbl[i].ov, tbl[i].no, tbl[i].rr);
      check($sformatf("nominal_%0d", i), {8'h00, pack_act()},
            {8'h00, tbl[i].e_busy, tbl[i].e_done, 1'b0, tbl[i].e_rdy, tbl[i].e_nv,
             tbl[i].e_ni, tbl[i].e_rv, tbl[i].e_idx, tbl[i].e_rd});
    end

    // Gapped input: valid pattern 1,0,1,1,0,1.
    gp = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    pulses = 0;
    cyc(1'b1, 1'b0, 8'h00, 3'b000, 24'h000000, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, gp[i], 8'(8'h40 + i), 3'b000, 24'h000000, 1'b0);
      check("gap_nv", {31'd0, neu_in_valid}, {31'd0, gp[i]});
      if (neu_in_valid) pulses++;
    end
    check("gap_pulses", 32'(pulses), 32'd4);
    check("gap_ready_low", {31'd0, in_ready}, 32'd0);
    finish_pass("gap_tail");

    // Out-of-order and repeated capture.
    start_feed4();
    cyc(1'b0, 1'b0, 8'h00, 3'b100, 24'hA20000, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 3'b011, 24'h00B1B0, 1'b0);
    check("ooo_not_yet", {31'd0, res_valid}, 32'd0);
    cyc(1'b0, 1'b0, 8'h00, 3'b100, 24'hC20000, 1'b0);
    check("ooo_drain_start", {31'd0, res_valid}, 32'd1);
    check("ooo_r0", {22'd0, res_idx, res_data}, {22'd0, 2'd0, 8'hB0});
    cyc(1'b0, 1'b0, 8'h00, 3'b000, 24'h000000, 1'b1);
    check("ooo_r1", {22'd0, res_idx, res_data}, {22'd0, 2'd1, 8'hB1});
    cyc(1'b0, 1'b0, 8'h00, 3'b000, 24'h000000, 1'b1);
    check("repeat_keep", {22'd0, res_idx, res_data}, {22'd0, 2'd2, 8'hA2});
    cyc(1'b0, 1'b0, 8'h00, 3'b000, 24'h000000, 1'b1);
    check("ooo_done", {31'd0, done}, 32'd1);
    idle_cyc(1'b0);
    check("ooo_done_once", {30'd0, done, busy}, 32'd0);

    // Timeout: only neuron 0 answers.
    start_feed4();
    cyc(1'b0, 1'b0, 8'h00, 3'b001, 24'h00005A, 1'b0);
    for (int i = 0; i < 14; i++) idle_cyc(1'b0);
    check("to_not_early", {31'd0, err_timeout}, 32'd0);
    idle_cyc(1'b0);
    check("to_set", {30'd0, err_timeout, res_valid}, 32'd3);
    check("to_d0", {22'd0, res_idx, res_data}, {22'd0, 2'd0, 8'h5A});
    idle_cyc(1'b1);
    check("to_d1", {22'd0, res_idx, res_data}, {22'd0, 2'd1, 8'h00});
    idle_cyc(1'b1);
    check("to_d2", {22'd0, res_idx, res_data}, {22'd0, 2'd2, 8'h00});
    idle_cyc(1'b1);
    idle_cyc(1'b0);
    idle_cyc(1'b0);
    check("to_sticky", {31'd0, err_timeout}, 32'd1);
    cyc(1'b1, 1'b0, 8'h00, 3'b000, 24'h000000, 1'b0);
    check("to_clear", {31'd0, err_timeout}, 32'd0);
    finish_pass("to_tail");

    // Backpressure: ready 0,0,1 per result.
    start_feed4();
    cyc(1'b0, 1'b0, 8'h00, 3'b111, 24'h332211, 1'b0);
    idle_cyc(1'b0);
    for (int i = 0; i < NN; i++) begin
      logic [7:0] ed;
      ed = 8'(17 * (i + 1));
      check("bp_present", {21'd0, res_valid, res_idx, res_data}, {21'd0, 1'b1, 2'(i), ed});
      idle_cyc(1'b0);
      check("bp_hold1", {21'd0, res_valid, res_idx, res_data}, {21'd0, 1'b1, 2'(i), ed});
      idle_cyc(1'b0);
      check("bp_hold2", {21'd0, res_valid, res_idx, res_data}, {21'd0, 1'b1, 2'(i), ed});
      idle_cyc(1'b1);
    end
    check("bp_done", {31'd0, done}, 32'd1);
    idle_cyc(1'b0);

    // Start while busy must not restart the pass.
    cyc(1'b1, 1'b0, 8'h00, 3'b000, 24'h000000, 1'b0);
    cyc(1'b0, 1'b1, 8'h75, 3'b000, 24'h000000, 1'b0);
    cyc(1'b0, 1'b1, 8'h76, 3'b000, 24'h000000, 1'b0);
    cyc(1'b1, 1'b1, 8'h77, 3'b000, 24'h000000, 1'b0);
    check("busy_start_ready", {31'd0, in_ready}, 32'd1);
    cyc(1'b0, 1'b1, 8'h78, 3'b000, 24'h000000, 1'b0);
    check("busy_start_norestart", {23'd0, in_ready, neu_in}, {23'd0, 1'b0, 8'h78});
    finish_pass("busy_tail");

    // Asynchronous reset mid-FEED and mid-DRAIN.
    cyc(1'b1, 1'b0, 8'h00, 3'b000, 24'h000000, 1'b0);
    cyc(1'b0, 1'b1, 8'h91, 3'b001, 24'h0000EE, 1'b0);
    cyc(1'b0, 1'b1, 8'h92, 3'b000, 24'h000000, 1'b0);
    async_reset("rst_mid_feed");
    start_feed4();
    cyc(1'b0, 1'b0, 8'h00, 3'b111, 24'h9A8B7C, 1'b0);
    idle_cyc(1'b0);
    idle_cyc(1'b1);
    async_reset("rst_mid_drain");

    // Randomized passes against the model.
    for (int p = 0; p < 40; p++) begin
      logic [NN-1:0] live;
      int budget;
      live = (p % 4 == 3) ? NN'($urandom) : 3'b111;
      budget = 0;
      cyc(1'b1, 1'($urandom), 8'($urandom), 3'b000, 24'($urandom), 1'b0);
      while (m_active && budget < 300) begin
        logic [NN-1:0] ov;
        ov = ($urandom_range(0, 3) == 0) ? (NN'($urandom) & live) : 3'b000;
        cyc(1'($urandom_range(0, 7) == 0), 1'($urandom), 8'($urandom), ov,
            24'($urandom), 1'($urandom));
        budget++;
      end
      check("rand_pass_ends", {31'd0, busy}, 32'd0);
      for (int j = 0; j < int'($urandom_range(0, 2)); j++)
        cyc(1'b0, 1'($urandom), 8'($urandom), NN'($urandom), 24'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
